if_fetch_unit: RTL and testbench

- Instruction-fetch stage that produces the IF/ID register inputs: PC, next PC (pcmux), instruction word, valid flag and the IF/ID load strobe.
- Owns the PC register and runs the read handshake to the instruction cache.
- Handles downstream stalls by buffering one fetched instruction.
- Handles control-flow redirects from EX, including a redirect that arrives while a cache read is still in flight.

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// I-cache read bus between the fetch unit (master) and the instruction cache (slave).
//   inst_read  : read request, held with a constant inst_addr until inst_resp
//   inst_addr  : read address
//   inst_resp  : one-cycle response pulse, inst_rdata valid in the same cycle
//   inst_rdata : instruction word
interface if_fetch_unit_if #(
  parameter int width = 32
);
  logic             inst_read;
  logic [width-1:0] inst_addr;
  logic             inst_resp;
  logic [width-1:0] inst_rdata;

  modport master (
    output inst_read,
    output inst_addr,
    input  inst_resp,
    input  inst_rdata
  );

  modport slave (
    input  inst_read,
    input  inst_addr,
    output inst_resp,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs the I-cache read handshake and
// produces the IF/ID register inputs. One fetched instruction can be parked
// while IF/ID stalls, and EX redirects are honoured even with a read in flight.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   icache       : I-cache read bus (master side)
//   stall_in     : IF/ID cannot accept this cycle
//   redirect     : taken branch/jump from EX, target in redirect_pc
//   load_if_id   : IF/ID load strobe
//   pc_out       : PC of the presented instruction
//   pcmux_out    : next PC selected this cycle
//   instr_out    : presented instruction word
//   valid_out    : presented instruction is real (0 = bubble)
//
// state | meaning
// IDLE  | first cycle after reset, no read issued
// WAIT  | read outstanding at pc
// HOLD  | IF/ID stalled, fetched instruction parked in buffer/bpc
module if_fetch_unit #(
  parameter int               width     = 32,
  parameter logic [width-1:0] RESET_PC  = 32'h00000060,
  parameter logic [width-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_unit_if.master  icache,
  input  logic             stall_in,
  input  logic             redirect,
  input  logic [width-1:0] redirect_pc,
  output logic             load_if_id,
  output logic [width-1:0] pc_out,
  output logic [width-1:0] pcmux_out,
  output logic [width-1:0] instr_out,
  output logic             valid_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [width-1:0] pc;
  logic [width-1:0] tgt;
  logic [width-1:0] bpc;
  logic [width-1:0] buffer;
  logic             kill;

  logic [width-1:0] pc_inc;
  logic [width-1:0] bpc_inc;
  logic             pending;

  assign pc_inc  = pc + width'(4);
  assign bpc_inc = bpc + width'(4);

  // A read is still outstanding only if we are waiting and it did not return now;
  // a redirect then has to be deferred through kill/tgt so inst_addr stays put.
  assign pending = (state == WAIT) && !icache.inst_resp;

  assign icache.inst_read = (state == WAIT);
  assign icache.inst_addr = pc;

  always_comb begin
    load_if_id = 1'b0;
    pc_out     = pc;
    pcmux_out  = pc;
    instr_out  = NOP_INSTR;
    valid_out  = 1'b0;
    if (redirect) begin
      // flush bubble; any response this cycle is dropped
      pcmux_out  = redirect_pc;
      load_if_id = !stall_in;
    end else begin
      case (state)
        WAIT: begin
          if (icache.inst_resp) begin
            if (kill) begin
              pcmux_out = tgt;
            end else begin
              pcmux_out = pc_inc;
              if (!stall_in) begin
                load_if_id = 1'b1;
                instr_out  = icache.inst_rdata;
                valid_out  = 1'b1;
              end
            end
          end
        end
        HOLD: begin
          pc_out     = bpc;
          instr_out  = buffer;
          valid_out  = 1'b1;
          pcmux_out  = bpc_inc;
          load_if_id = !stall_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      kill   <= 1'b0;
      tgt    <= RESET_PC;
      bpc    <= RESET_PC;
      buffer <= NOP_INSTR;
    end else if (redirect) begin
      buffer <= NOP_INSTR;
      if (pending) begin
        kill <= 1'b1;
        tgt  <= redirect_pc;
      end else begin
        pc    <= redirect_pc;
        kill  <= 1'b0;
        state <= WAIT;
      end
    end else begin
      case (state)
        IDLE: state <= WAIT;
        WAIT: begin
          if (icache.inst_resp) begin
            if (kill) begin
              pc   <= tgt;
              kill <= 1'b0;
            end else if (stall_in) begin
              buffer <= icache.inst_rdata;
              bpc    <= pc;
              pc     <= pc_inc;
              state  <= HOLD;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (!stall_in) state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural I-cache with programmable
// latency, scoreboard of expected IF/ID loads, and per-scenario directed checks.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        load_if_id;
  logic [31:0] pc_out;
  logic [31:0] pcmux_out;
  logic [31:0] instr_out;
  logic        valid_out;

  if_fetch_unit_if #(.width(32)) icache ();

  if_fetch_unit #(
    .width(32),
    .RESET_PC(32'h00000060),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .icache(icache),
    .stall_in(stall_in),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .load_if_id(load_if_id),
    .pc_out(pc_out),
    .pcmux_out(pcmux_out),
    .instr_out(instr_out),
    .valid_out(valid_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcmux;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   lat      = 1;
  bit   cache_en = 0;
  bit   inject   = 0;
  int   cnt      = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h60) return 32'h00A00093;
    if (a == 32'h64) return 32'h00B00113;
    return a * 3 + 32'h00000013;
  endfunction

  // I-cache model: response in the lat-th cycle of a held request
  always @(posedge clk) begin
    #1;
    if (inject) begin
      icache.inst_resp  = 1'b1;
      icache.inst_rdata = 32'hDEADBEEF;
      inject = 0;
    end else if (rst) begin
      icache.inst_resp = 1'b0;
      cnt = 0;
    end else if (icache.inst_read && cache_en) begin
      cnt++;
      if (cnt >= lat) begin
        icache.inst_resp  = 1'b1;
        icache.inst_rdata = mem(icache.inst_addr);
        cnt = 0;
      end else begin
        icache.inst_resp = 1'b0;
      end
    end else begin
      icache.inst_resp = 1'b0;
      cnt = 0;
    end
  end

  // Scoreboard monitor plus address-stability check on pending reads
  bit          prev_pending = 0;
  logic [31:0] prev_addr;
  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 0;
    end else begin
      if (load_if_id && valid_out) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_load: got pc %h instr %h, expected no valid load", pc_out, instr_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pc_out !== e.pc || instr_out !== e.instr || pcmux_out !== e.pcmux) begin
            n_fail++;
            $display("FAIL sb_load: got pc %h instr %h pcmux %h, expected pc %h instr %h pcmux %h",
                     pc_out, instr_out, pcmux_out, e.pc, e.instr, e.pcmux);
          end
        end
      end
      if (prev_pending && icache.inst_read) begin
        n_tests++;
        if (icache.inst_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_stable: got %h, expected %h", icache.inst_addr, prev_addr);
        end
      end
      prev_pending = icache.inst_read && !icache.inst_resp;
      prev_addr    = icache.inst_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pcmux);
    exp_t e;
    e.pc = pc; e.instr = mem(pc); e.pcmux = pcmux;
    exp_q.push_back(e);
  endtask

  // Leaves the bench at posedge+1 of the IDLE cycle following reset
  task automatic do_reset(input int l, input bit en);
    rst = 1; redirect = 0; stall_in = 0; redirect_pc = 0;
    lat = l; cache_en = en;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset(1, 0);
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b expected 0", icache.inst_read); end
    n_tests++; if (icache.inst_addr !== 32'h60) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000060", icache.inst_addr); end
    n_tests++; if (load_if_id !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_load_valid: got %b%b expected 00", load_if_id, valid_out); end
    n_tests++; if (instr_out !== 32'h13 || pc_out !== 32'h60) begin n_fail++; $display("FAIL rst_data: got instr %h pc %h expected 00000013 00000060", instr_out, pc_out); end
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b1 || icache.inst_addr !== 32'h60) begin n_fail++; $display("FAIL first_read: got %b %h expected 1 00000060", icache.inst_read, icache.inst_addr); end
  endtask

  task automatic test_sequential();
    do_reset(1, 1);
    push(32'h60, 32'h64); push(32'h64, 32'h68); push(32'h68, 32'h6C); push(32'h6C, 32'h70);
    tick();
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b1) begin n_fail++; $display("FAIL seq_first_load: got %b expected 1", load_if_id); end
    tick(); tick(); tick();
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b1) begin n_fail++; $display("FAIL seq_throughput: got %b expected 1", load_if_id); end
    cache_en = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_addr !== 32'h70 || load_if_id !== 1'b0) begin n_fail++; $display("FAIL seq_next_addr: got %h load %b expected 00000070 0", icache.inst_addr, load_if_id); end
  endtask

  task automatic test_stall();
    do_reset(1, 1);
    tick(); stall_in = 1;
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b0) begin n_fail++; $display("FAIL stall_resp_load: got %b expected 0", load_if_id); end
    cache_en = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b0) begin n_fail++; $display("FAIL hold_read: got %b expected 0", icache.inst_read); end
    n_tests++; if (pc_out !== 32'h60 || instr_out !== 32'h00A00093 || valid_out !== 1'b1 || load_if_id !== 1'b0) begin
      n_fail++; $display("FAIL hold_outputs: got pc %h instr %h v %b ld %b expected 00000060 00a00093 1 0", pc_out, instr_out, valid_out, load_if_id); end
    tick();
    @(negedge clk);
    push(32'h60, 32'h64);
    tick(); stall_in = 0;
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b1) begin n_fail++; $display("FAIL hold_release_load: got %b expected 1", load_if_id); end
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b1 || icache.inst_addr !== 32'h64) begin n_fail++; $display("FAIL hold_next_addr: got %b %h expected 1 00000064", icache.inst_read, icache.inst_addr); end
  endtask

  task automatic test_redirect_pending();
    do_reset(1, 1);
    push(32'h60, 32'h64); push(32'h64, 32'h68);
    tick(); tick();
    @(negedge clk);
    lat = 4;
    tick();
    tick(); redirect = 1; redirect_pc = 32'h200;
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b1 || valid_out !== 1'b0 || instr_out !== 32'h13 || pcmux_out !== 32'h200) begin
      n_fail++; $display("FAIL redir_bubble: got ld %b v %b instr %h pcmux %h expected 1 0 00000013 00000200", load_if_id, valid_out, instr_out, pcmux_out); end
    n_tests++; if (icache.inst_addr !== 32'h68) begin n_fail++; $display("FAIL redir_addr_hold: got %h expected 00000068", icache.inst_addr); end
    tick(); redirect = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_resp !== 1'b1 || load_if_id !== 1'b0 || icache.inst_addr !== 32'h68) begin
      n_fail++; $display("FAIL killed_resp: got resp %b ld %b addr %h expected 1 0 00000068", icache.inst_resp, load_if_id, icache.inst_addr); end
    cache_en = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b1 || icache.inst_addr !== 32'h200) begin n_fail++; $display("FAIL redir_target: got %b %h expected 1 00000200", icache.inst_read, icache.inst_addr); end
  endtask

  task automatic test_redirect_with_resp();
    do_reset(1, 1);
    push(32'h60, 32'h64); push(32'h64, 32'h68); push(32'h68, 32'h6C); push(32'h6C, 32'h70);
    tick(); tick(); tick(); tick();
    tick(); redirect = 1; redirect_pc = 32'h300;
    @(negedge clk);
    n_tests++; if (icache.inst_resp !== 1'b1 || valid_out !== 1'b0 || pcmux_out !== 32'h300) begin
      n_fail++; $display("FAIL redir_resp: got resp %b v %b pcmux %h expected 1 0 00000300", icache.inst_resp, valid_out, pcmux_out); end
    cache_en = 0;
    tick(); redirect = 0;
    @(negedge clk);
    n_tests++; if (icache.inst_addr !== 32'h300 || load_if_id !== 1'b0) begin n_fail++; $display("FAIL redir_resp_next: got %h ld %b expected 00000300 0", icache.inst_addr, load_if_id); end
  endtask

  task automatic test_redirect_hold();
    do_reset(1, 1);
    tick(); stall_in = 1;
    @(negedge clk);
    cache_en = 0;
    tick(); redirect = 1; redirect_pc = 32'h400;
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL redir_hold: got ld %b v %b expected 0 0", load_if_id, valid_out); end
    tick(); redirect = 0; stall_in = 0;
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b1 || icache.inst_addr !== 32'h400 || load_if_id !== 1'b0) begin
      n_fail++; $display("FAIL redir_hold_next: got rd %b addr %h ld %b expected 1 00000400 0", icache.inst_read, icache.inst_addr, load_if_id); end
  endtask

  task automatic test_wrap();
    do_reset(1, 0);
    redirect = 1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    n_tests++; if (pcmux_out !== 32'hFFFFFFFC || valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_redir: got pcmux %h v %b expected fffffffc 0", pcmux_out, valid_out); end
    cache_en = 1;
    push(32'hFFFFFFFC, 32'h0);
    tick(); redirect = 0;
    @(negedge clk);
    n_tests++; if (load_if_id !== 1'b1 || pcmux_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pcmux: got ld %b pcmux %h expected 1 00000000", load_if_id, pcmux_out); end
    cache_en = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", icache.inst_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(8, 1);
    tick(); tick();
    tick(); rst = 1;
    @(negedge clk);
    inject = 1;
    tick(); rst = 0;
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b0 || pc_out !== 32'h60) begin n_fail++; $display("FAIL midrst_idle: got rd %b pc %h expected 0 00000060", icache.inst_read, pc_out); end
    n_tests++; if (load_if_id !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst_late_resp: got ld %b v %b expected 0 0", load_if_id, valid_out); end
    cache_en = 0;
    tick();
    @(negedge clk);
    n_tests++; if (icache.inst_read !== 1'b1 || icache.inst_addr !== 32'h60 || load_if_id !== 1'b0) begin
      n_fail++; $display("FAIL midrst_resume: got rd %b addr %h ld %b expected 1 00000060 0", icache.inst_read, icache.inst_addr, load_if_id); end
  endtask

  initial begin
    rst = 1; stall_in = 0; redirect = 0; redirect_pc = 0;
    icache.inst_resp = 0; icache.inst_rdata = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_pending();
    test_redirect_with_resp();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d loads outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
